// File: rtl/regfile_wb_sched_if.sv
// Writeback-scheduler bus: requester handshake, register-file write port,
// issue-stage hazard query and scoreboard status.
interface regfile_wb_sched_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic                 stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wen;
    logic [AW-1:0]        wadd;
    logic [DW-1:0]        wdata;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic [AW-1:0]        iss_rs1;
    logic [AW-1:0]        iss_rs2;
    logic                 iss_hazard;
    logic [(2**AW)-1:0]   busy;
    logic [AW:0]          pend_cnt;
    logic                 err;

    modport master (
        output stall, req_valid, req_addr, req_data,
               iss_valid, iss_rd, iss_rs1, iss_rs2,
        input  req_ready, wen, wadd, wdata, iss_hazard, busy, pend_cnt, err
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
               iss_valid, iss_rd, iss_rs1, iss_rs2,
        output req_ready, wen, wadd, wdata, iss_hazard, busy, pend_cnt, err
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin arbiter for the register-file write port, with a one-entry
// registered write slot that holds across stalls and a busy-register scoreboard.
module regfile_wb_sched #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    regfile_wb_sched_if.slave  bus
);
    localparam int NREG = 2**AW;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q,   ptr_d;
    logic            wen_q,   wen_d;
    logic [AW-1:0]   wadd_q,  wadd_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] busy_q,  busy_d;
    logic [AW:0]     cnt_q,   cnt_d;
    logic            err_q,   err_d;

    logic            slot_free_s;
    logic            commit_s;
    logic            grant_any_s;
    logic [NREQ-1:0] grant_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;
    logic            hazard_s;
    logic            issue_s;

    function automatic int rr_idx(input int p, input int k);
        return (p + k) % NREQ;
    endfunction

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Round-robin grant: first valid requester at or after the pointer.
    always_comb begin
        grant_s     = '0;
        grant_any_s = 1'b0;
        sel_addr_s  = '0;
        sel_data_s  = '0;
        ptr_d       = ptr_q;
        slot_free_s = ~wen_q | ~bus.stall;
        if (slot_free_s && !bus.stall) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_any_s && bus.req_valid[rr_idx(int'(ptr_q), k)]) begin
                    grant_any_s = 1'b1;
                    grant_s[rr_idx(int'(ptr_q), k)] = 1'b1;
                    sel_addr_s = bus.req_addr[rr_idx(int'(ptr_q), k)*AW +: AW];
                    sel_data_s = bus.req_data[rr_idx(int'(ptr_q), k)*DW +: DW];
                    ptr_d      = PW'(rr_idx(int'(ptr_q), k + 1));
                end else begin
                    grant_s = grant_s;
                end
            end
        end else begin
            grant_any_s = 1'b0;
        end
    end

    // Hazard uses registered busy only; a retiring register still blocks issue.
    always_comb begin
        hazard_s = bus.iss_valid &
                   (busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] | busy_q[bus.iss_rd]);
        issue_s  = bus.iss_valid & ~hazard_s & ~bus.stall & (bus.iss_rd != {AW{1'b0}});
        commit_s = wen_q & ~bus.stall;
    end

    // Write slot next state: load on transfer (x0 dropped), clear on commit, else hold.
    always_comb begin
        wen_d   = wen_q;
        wadd_d  = wadd_q;
        wdata_d = wdata_q;
        if (grant_any_s) begin
            if (sel_addr_s != {AW{1'b0}}) begin
                wen_d   = 1'b1;
                wadd_d  = sel_addr_s;
                wdata_d = sel_data_s;
            end else begin
                wen_d   = 1'b0;
            end
        end else if (commit_s) begin
            wen_d = 1'b0;
        end else begin
            wen_d = wen_q;
        end
    end

    // Scoreboard: clear on retire, then set on issue so a forced collision sets.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (commit_s) begin
            if (!busy_q[wadd_q]) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            busy_d[wadd_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (issue_s) begin
            busy_d[bus.iss_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
        cnt_d     = popcount(busy_d);
    end

    // State registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q   <= '0;
            wen_q   <= 1'b0;
            wadd_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            wadd_q  <= wadd_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = grant_s;
    assign bus.wen        = wen_q;
    assign bus.wadd       = wadd_q;
    assign bus.wdata      = wdata_q;
    assign bus.iss_hazard = hazard_s;
    assign bus.busy       = busy_q;
    assign bus.pend_cnt   = cnt_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a behavioural model.
module tb_regfile_wb_sched;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    regfile_wb_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();
    regfile_wb_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state.
    bit            m_busy [NREG];
    bit            m_wen;
    logic [AW-1:0] m_wadd;
    logic [DW-1:0] m_wdata;
    int            m_ptr;
    bit            m_err;
    int            m_last_grant;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_wen = 1'b0; m_wadd = '0; m_wdata = '0; m_ptr = 0; m_err = 1'b0; m_last_grant = -1;
    endtask

    function automatic int model_grant();
        bit slot_free;
        slot_free = !m_wen || !bus.stall;
        if (!slot_free || bus.stall) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit model_hazard();
        return bus.iss_valid && (m_busy[bus.iss_rs1] || m_busy[bus.iss_rs2] || m_busy[bus.iss_rd]);
    endfunction

    task automatic model_step();
        int g;
        bit commit, hz;
        logic [AW-1:0] a;
        g      = model_grant();
        commit = m_wen && !bus.stall;
        hz     = model_hazard();
        if (commit) begin
            if (!m_busy[m_wadd]) m_err = 1'b1;
            m_busy[m_wadd] = 1'b0;
        end
        if (bus.iss_valid && !hz && !bus.stall && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            a = bus.req_addr[g*AW +: AW];
            if (a != 0) begin
                m_wen = 1'b1; m_wadd = a; m_wdata = bus.req_data[g*DW +: DW];
            end else begin
                m_wen = 1'b0;
            end
        end else if (commit) begin
            m_wen = 1'b0;
        end
        m_last_grant = g;
    endtask

    task automatic compare_all();
        int g, cnt;
        logic [NREQ-1:0] er;
        logic [NREG-1:0] eb;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        cnt = 0;
        for (int i = 0; i < NREG; i++) begin
            eb[i] = m_busy[i];
            cnt += int'(m_busy[i]);
        end
        check("req_ready", 64'(bus.req_ready), 64'(er));
        check("wen", 64'(bus.wen), 64'(m_wen));
        if (m_wen) begin
            check("wadd", 64'(bus.wadd), 64'(m_wadd));
            check("wdata", 64'(bus.wdata), 64'(m_wdata));
        end
        check("busy", 64'(bus.busy), 64'(eb));
        check("pend_cnt", 64'(bus.pend_cnt), 64'(cnt));
        check("err", 64'(bus.err), 64'(m_err));
        check("iss_hazard", 64'(bus.iss_hazard), 64'(model_hazard()));
    endtask

    task automatic settle();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic advance();
        @(posedge CLK);
        model_step();
        #2;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic set_iss(input bit v, input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        bus.iss_valid = v; bus.iss_rd = rd; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.stall = 1'b0; bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        set_iss(1'b0, '0, '0, '0);
        model_reset();
        #1;
        check("rst_wen", 64'(bus.wen), 64'd0);
        check("rst_wadd", 64'(bus.wadd), 64'd0);
        check("rst_wdata", 64'(bus.wdata), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_pend", 64'(bus.pend_cnt), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    initial begin
        do_reset();
        // Idle after reset.
        settle();
        check("idle_ready", 64'(bus.req_ready), 64'd0);
        check("idle_wen", 64'(bus.wen), 64'd0);
        advance();

        // Issue x5, then requester 1 writes it.
        set_iss(1'b1, 5'd5, 5'd0, 5'd0);
        cyc();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        settle();
        check("x5_ready", 64'(bus.req_ready), 64'b010);
        check("x5_busy_before", 64'(bus.busy), 64'h20);
        check("x5_pend_before", 64'(bus.pend_cnt), 64'd1);
        advance();
        set_req(1, 1'b0, 5'd0, 32'd0);
        settle();
        check("x5_wen", 64'(bus.wen), 64'd1);
        check("x5_wadd", 64'(bus.wadd), 64'd5);
        check("x5_wdata", 64'(bus.wdata), 64'hDEADBEEF);
        check("x5_busy_retire", 64'(bus.busy), 64'h20);
        advance();
        settle();
        check("x5_wen_after", 64'(bus.wen), 64'd0);
        check("x5_busy_after", 64'(bus.busy), 64'd0);
        check("x5_pend_after", 64'(bus.pend_cnt), 64'd0);
        check("x5_err", 64'(bus.err), 64'd0);
        advance();

        // All requesters valid: rotating grants, back-to-back writes.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), DW'(i));
        for (int c = 0; c < 6; c++) begin
            settle();
            check("rr_ready", 64'(bus.req_ready), 64'(1 << (c % 3)));
            if (c > 0) begin
                check("rr_wen", 64'(bus.wen), 64'd1);
                check("rr_wadd", 64'(bus.wadd), 64'(((c - 1) % 3) + 1));
            end
            advance();
        end
        bus.req_valid = '0;

        // Hold x7 through a 4-cycle stall while another requester waits.
        do_reset();
        set_iss(1'b1, 5'd7, 5'd0, 5'd0);
        cyc();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_req(0, 1'b1, 5'd7, 32'h1234);
        cyc();
        bus.stall = 1'b1;
        set_req(0, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b1, 5'd8, 32'h55);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("hold_wen", 64'(bus.wen), 64'd1);
            check("hold_wadd", 64'(bus.wadd), 64'd7);
            check("hold_wdata", 64'(bus.wdata), 64'h1234);
            check("hold_ready", 64'(bus.req_ready), 64'd0);
            check("hold_busy", 64'(bus.busy), 64'h80);
            advance();
        end
        bus.stall = 1'b0;
        settle();
        check("unstall_ready", 64'(bus.req_ready), 64'b010);
        advance();
        set_req(1, 1'b0, 5'd0, 32'd0);
        settle();
        check("commit_busy", 64'(bus.busy), 64'd0);
        check("next_wadd", 64'(bus.wadd), 64'd8);
        advance();

        // Asynchronous reset in the middle of a held write.
        do_reset();
        set_iss(1'b1, 5'd7, 5'd0, 5'd0);
        cyc();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_req(0, 1'b1, 5'd7, 32'h77);
        cyc();
        set_req(0, 1'b0, 5'd0, 32'd0);
        bus.stall = 1'b1;
        cyc();
        check("pre_rst_wen", 64'(bus.wen), 64'd1);
        do_reset();

        // x0 write accepted and dropped; x0 never busy.
        set_req(2, 1'b1, 5'd0, 32'hABCD);
        set_iss(1'b1, 5'd0, 5'd0, 5'd0);
        settle();
        check("x0_ready", 64'(bus.req_ready), 64'b100);
        check("x0_hazard", 64'(bus.iss_hazard), 64'd0);
        advance();
        set_req(2, 1'b0, 5'd0, 32'd0);
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        settle();
        check("x0_wen", 64'(bus.wen), 64'd0);
        check("x0_busy", 64'(bus.busy), 64'd0);
        advance();

        // RAW on x9 through its retire cycle; then write to non-busy x12.
        do_reset();
        set_iss(1'b1, 5'd9, 5'd0, 5'd0);
        cyc();
        set_iss(1'b1, 5'd10, 5'd0, 5'd9);
        set_req(0, 1'b1, 5'd9, 32'h99);
        settle();
        check("raw_hazard", 64'(bus.iss_hazard), 64'd1);
        advance();
        set_req(0, 1'b0, 5'd0, 32'd0);
        settle();
        check("retire_wadd", 64'(bus.wadd), 64'd9);
        check("retire_hazard", 64'(bus.iss_hazard), 64'd1);
        advance();
        settle();
        check("after_hazard", 64'(bus.iss_hazard), 64'd0);
        check("pre_err", 64'(bus.err), 64'd0);
        advance();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_req(1, 1'b1, 5'd12, 32'h12);
        cyc();
        set_req(1, 1'b0, 5'd0, 32'd0);
        cyc();
        settle();
        check("err_set", 64'(bus.err), 64'd1);
        advance();
        for (int c = 0; c < 3; c++) cyc();
        settle();
        check("err_sticky", 64'(bus.err), 64'd1);
        advance();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || m_last_grant == i) begin
                    set_req(i, ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), DW'($urandom));
                end
            end
            bus.stall = ($urandom_range(0, 3) == 0);
            set_iss(($urandom_range(0, 1) == 1), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
